cacheline_adaptor: RTL and testbench

CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

---
 rtl/cache_types.sv | 20 ++
 rtl/cacheline_adaptor.sv | 115 +++++++++++
 tb/tb_cacheline_adaptor.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_types.sv
// Shared cache-side types for the cache line adaptor.
//   LINE_W / BURST_W : default cache line and memory beat widths
//   N_BEATS / BEAT_W : beats per line and beat-counter width
//   state_e          : adaptor control states
package cache_types;

  localparam int unsigned LINE_W  = 256;
  localparam int unsigned BURST_W = 64;
  localparam int unsigned N_BEATS = LINE_W / BURST_W;
  localparam int unsigned BEAT_W  = $clog2(N_BEATS);
  localparam int unsigned ADDR_W  = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    DONE     = 2'd3
  } state_e;

endpackage

// File: rtl/cacheline_adaptor.sv
// Cache line <-> memory burst adaptor. Splits a cache line write into
// BURST_W-wide beats and assembles read beats into a full cache line.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   line_i, address_i, read_i,
//   write_i / line_o, resp_o        cache side
//   burst_i, resp_i / burst_o,
//   address_o, read_o, write_o      memory side
module cacheline_adaptor #(
  parameter int unsigned LINE_W  = cache_types::LINE_W,
  parameter int unsigned BURST_W = cache_types::BURST_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);

  import cache_types::*;

  localparam int unsigned BEATS  = LINE_W / BURST_W;
  localparam int unsigned CNT_W  = $clog2(BEATS);
  localparam int unsigned OFF_M  = (LINE_W / 8) - 1;

  state_e             state;
  logic [CNT_W-1:0]   k;
  logic [CNT_W-1:0]   k_nxt;
  logic [LINE_W-1:0]  line_buf;
  logic [31:0]        addr_aligned;
  logic               last_beat;

  // Line-aligned request address and beat bookkeeping
  always_comb begin
    addr_aligned = address_i & ~32'(OFF_M);
    k_nxt        = k + CNT_W'(1);
    last_beat    = (k == CNT_W'(BEATS - 1));
  end

  // The line buffer doubles as the read line seen by the cache
  assign line_o = line_buf;

  // Control FSM with all datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      k         <= '0;
      resp_o    <= 1'b0;
      read_o    <= 1'b0;
      write_o   <= 1'b0;
      address_o <= '0;
      burst_o   <= '0;
      line_buf  <= '0;
    end else begin
      resp_o <= 1'b0;
      case (state)
        IDLE: begin
          k <= '0;
          // Write wins a simultaneous request: a dirty victim leaves first
          if (write_i) begin
            line_buf  <= line_i;
            address_o <= addr_aligned;
            burst_o   <= line_i[BURST_W-1:0];
            write_o   <= 1'b1;
            state     <= WR_BURST;
          end else if (read_i) begin
            address_o <= addr_aligned;
            read_o    <= 1'b1;
            state     <= RD_BURST;
          end
        end
        RD_BURST: begin
          if (resp_i) begin
            line_buf[32'(k) * BURST_W +: BURST_W] <= burst_i;
            k <= k_nxt;
            if (last_beat) begin
              read_o <= 1'b0;
              resp_o <= 1'b1;
              state  <= DONE;
            end
          end
        end
        WR_BURST: begin
          if (resp_i) begin
            k <= k_nxt;
            // Present the next beat in the cycle after the acknowledge
            burst_o <= line_buf[32'(k_nxt) * BURST_W +: BURST_W];
            if (last_beat) begin
              write_o <= 1'b0;
              resp_o  <= 1'b1;
              burst_o <= '0;
              state   <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench for cacheline_adaptor: table-driven transactions
// plus hand-written reset, idle-acknowledge and back-to-back sequences.
module tb_cacheline_adaptor;

  logic         clk;
  logic         rst_n;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  int checks;
  int failures;

  cacheline_adaptor #(.LINE_W(256), .BURST_W(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic             rd;
    logic             wr;
    logic [31:0]      addr;
    logic [255:0]     line_in;
    logic [3:0][63:0] beats;     // read data to drive / write data expected
    int               gap;       // idle cycles before each acknowledge
    logic [31:0]      exp_addr;
    logic [255:0]     exp_line;
    logic             exp_rd;
    logic             exp_wr;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_req(input vec_t v);
    read_i    = v.rd;
    write_i   = v.wr;
    address_i = v.addr;
    line_i    = v.line_in;
  endtask

  // Entered one cycle after the request edge; leaves in the IDLE cycle after DONE
  task automatic run_body(input vec_t v, input bit has_next, input vec_t nv);
    chk("rd_o_start", 256'(read_o), 256'(v.exp_rd));
    chk("wr_o_start", 256'(write_o), 256'(v.exp_wr));
    chk("addr_o", 256'(address_o), 256'(v.exp_addr));
    // Requests outside IDLE must be ignored; flip them to prove it
    read_i  = 1'b1;
    write_i = 1'b1;
    for (int b = 0; b < 4; b++) begin
      for (int g = 0; g < v.gap; g++) begin
        resp_i  = 1'b0;
        burst_i = {$urandom, $urandom};
        step();
        chk("wait_resp_o", 256'(resp_o), 256'(0));
        chk("wait_rd_o", 256'(read_o), 256'(v.exp_rd));
        chk("wait_wr_o", 256'(write_o), 256'(v.exp_wr));
        if (v.exp_wr) chk("wait_burst_o", 256'(burst_o), 256'(v.beats[b]));
      end
      if (v.exp_wr) chk("burst_o", 256'(burst_o), 256'(v.beats[b]));
      resp_i  = 1'b1;
      burst_i = v.exp_rd ? v.beats[b] : {$urandom, $urandom};
      step();
      resp_i = 1'b0;
      if (b < 3) chk("early_resp_o", 256'(resp_o), 256'(0));
    end
    chk("done_resp_o", 256'(resp_o), 256'(1));
    chk("done_rd_o", 256'(read_o), 256'(0));
    chk("done_wr_o", 256'(write_o), 256'(0));
    chk("done_line_o", line_o, v.exp_line);
    if (has_next) apply_req(nv);
    else begin
      read_i  = 1'b0;
      write_i = 1'b0;
    end
    step();
    chk("post_resp_o", 256'(resp_o), 256'(0));
    chk("hold_line_o", line_o, v.exp_line);
  endtask

  vec_t none;

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    line_i    = '0;
    address_i = '0;
    read_i    = 1'b0;
    write_i   = 1'b0;
    burst_i   = '0;
    resp_i    = 1'b0;
    none      = '{default: '0};

    vecs[0] = '{rd: 1'b1, wr: 1'b0, addr: 32'h0000_1234, line_in: '0,
                beats: {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                        64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                gap: 0, exp_addr: 32'h0000_1220,
                exp_line: {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                           64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                exp_rd: 1'b1, exp_wr: 1'b0};
    vecs[1] = '{rd: 1'b0, wr: 1'b1, addr: 32'h8000_00FF,
                line_in: {64'hCAFE_F00D_5555_AAAA, 64'hDEAD_BEEF_0000_0001,
                          64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF},
                beats: {64'hCAFE_F00D_5555_AAAA, 64'hDEAD_BEEF_0000_0001,
                        64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF},
                gap: 0, exp_addr: 32'h8000_00E0,
                exp_line: {64'hCAFE_F00D_5555_AAAA, 64'hDEAD_BEEF_0000_0001,
                           64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF},
                exp_rd: 1'b0, exp_wr: 1'b1};
    vecs[2] = '{rd: 1'b1, wr: 1'b1, addr: 32'h0000_0040,
                line_in: {64'hA3A3_A3A3_A3A3_A3A3, 64'hA2A2_A2A2_A2A2_A2A2,
                          64'hA1A1_A1A1_A1A1_A1A1, 64'hA0A0_A0A0_A0A0_A0A0},
                beats: {64'hA3A3_A3A3_A3A3_A3A3, 64'hA2A2_A2A2_A2A2_A2A2,
                        64'hA1A1_A1A1_A1A1_A1A1, 64'hA0A0_A0A0_A0A0_A0A0},
                gap: 0, exp_addr: 32'h0000_0040,
                exp_line: {64'hA3A3_A3A3_A3A3_A3A3, 64'hA2A2_A2A2_A2A2_A2A2,
                           64'hA1A1_A1A1_A1A1_A1A1, 64'hA0A0_A0A0_A0A0_A0A0},
                exp_rd: 1'b0, exp_wr: 1'b1};
    vecs[3] = '{rd: 1'b1, wr: 1'b0, addr: 32'hFFFF_FFFF, line_in: '1,
                beats: {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                        64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA},
                gap: 3, exp_addr: 32'hFFFF_FFE0,
                exp_line: {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                           64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA},
                exp_rd: 1'b1, exp_wr: 1'b0};
    vecs[4] = '{rd: 1'b0, wr: 1'b1, addr: 32'h1000_001F,
                line_in: {64'h0000_0000_0000_0004, 64'h0000_0000_0000_0003,
                          64'h0000_0000_0000_0002, 64'h0000_0000_0000_0001},
                beats: {64'h0000_0000_0000_0004, 64'h0000_0000_0000_0003,
                        64'h0000_0000_0000_0002, 64'h0000_0000_0000_0001},
                gap: 3, exp_addr: 32'h1000_0000,
                exp_line: {64'h0000_0000_0000_0004, 64'h0000_0000_0000_0003,
                           64'h0000_0000_0000_0002, 64'h0000_0000_0000_0001},
                exp_rd: 1'b0, exp_wr: 1'b1};

    // Reset state
    step();
    chk("rst_resp_o", 256'(resp_o), 256'(0));
    chk("rst_rd_o", 256'(read_o), 256'(0));
    chk("rst_wr_o", 256'(write_o), 256'(0));
    chk("rst_addr_o", 256'(address_o), 256'(0));
    chk("rst_burst_o", 256'(burst_o), 256'(0));
    chk("rst_line_o", line_o, 256'(0));
    rst_n = 1'b1;
    step();

    // Acknowledge with no burst in flight is ignored
    resp_i  = 1'b1;
    burst_i = 64'h5A5A_5A5A_5A5A_5A5A;
    step();
    step();
    resp_i = 1'b0;
    chk("idle_ack_rd_o", 256'(read_o), 256'(0));
    chk("idle_ack_wr_o", 256'(write_o), 256'(0));
    chk("idle_ack_resp_o", 256'(resp_o), 256'(0));
    chk("idle_ack_line_o", line_o, 256'(0));

    // Table-driven transactions
    for (int i = 0; i < 5; i++) begin
      apply_req(vecs[i]);
      step();
      run_body(vecs[i], 1'b0, none);
      step();
    end

    // Reset after beat 2 of a read abandons the burst
    apply_req(vecs[0]);
    step();
    for (int b = 0; b < 3; b++) begin
      resp_i  = 1'b1;
      burst_i = 64'hEEEE_0000_0000_0000 | 64'(b);
      step();
    end
    resp_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_rd_o", 256'(read_o), 256'(0));
    chk("arst_resp_o", 256'(resp_o), 256'(0));
    chk("arst_addr_o", 256'(address_o), 256'(0));
    chk("arst_burst_o", 256'(burst_o), 256'(0));
    chk("arst_line_o", line_o, 256'(0));
    read_i = 1'b0;
    step();
    rst_n = 1'b1;
    chk("arst_hold_resp_o", 256'(resp_o), 256'(0));
    step();
    chk("arst_after_resp_o", 256'(resp_o), 256'(0));
    chk("arst_after_rd_o", 256'(read_o), 256'(0));
    apply_req(vecs[0]);
    step();
    run_body(vecs[0], 1'b0, none);
    step();

    // Writeback immediately followed by allocate
    apply_req(vecs[1]);
    step();
    run_body(vecs[1], 1'b1, vecs[0]);
    chk("b2b_idle_rd_o", 256'(read_o), 256'(0));
    step();
    run_body(vecs[0], 1'b0, none);
    step();
    chk("final_resp_o", 256'(resp_o), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
